// File: rtl/fetch_step_controller.sv
// Fetch sequencing controller: conditions board buttons and switches, then issues
// single-step or free-running fetch pulses, halts on a PC breakpoint and clears the fetch unit.
module fetch_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RUN_DIV         = 4,
    parameter int unsigned PC_WIDTH        = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                RunSw,
    input  logic                StepBtn,
    input  logic                ClrBtn,
    input  logic                BkptEn,
    input  logic [PC_WIDTH-1:0] BkptAddr,
    input  logic [PC_WIDTH-1:0] PCResult,
    output logic                FetchEn,
    output logic                IfuReset,
    output logic                Halted,
    output logic [1:0]          State,
    output logic [15:0]         FetchCount
);

    localparam int unsigned NUM_IN = 3;
    localparam int unsigned RUN_I  = 0;
    localparam int unsigned STEP_I = 1;
    localparam int unsigned CLR_I  = 2;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TICK_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;
    logic [NUM_IN-1:0] deb;
    logic [DB_W-1:0]   db_cnt [NUM_IN];
    logic              step_deb_d;
    logic              clr_deb_d;
    logic              step_req;
    logic              clr_req;
    logic              run_lvl;

    state_t            state;
    state_t            state_nxt;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_nxt;
    logic [15:0]       count_nxt;
    logic              fetch_nxt;
    logic              ifu_nxt;
    logic              bkpt_hit;

    assign run_lvl  = deb[RUN_I];
    assign bkpt_hit = BkptEn && (PCResult == BkptAddr);

    // Synchronize, debounce and edge-detect the three board inputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            step_deb_d <= 1'b0;
            clr_deb_d  <= 1'b0;
            step_req   <= 1'b0;
            clr_req    <= 1'b0;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1      <= {ClrBtn, StepBtn, RunSw};
            sync2      <= sync1;
            step_deb_d <= deb[STEP_I];
            clr_deb_d  <= deb[CLR_I];
            step_req   <= deb[STEP_I] & ~step_deb_d;
            clr_req    <= deb[CLR_I] & ~clr_deb_d;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state and output decode; clear outranks breakpoint, which outranks mode logic
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        count_nxt = FetchCount;
        fetch_nxt = 1'b0;
        ifu_nxt   = 1'b0;
        if (clr_req) begin
            ifu_nxt   = 1'b1;
            count_nxt = '0;
            tick_nxt  = '0;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_lvl) begin
                        state_nxt = S_RUN;
                        tick_nxt  = '0;
                    end else if (step_req) begin
                        state_nxt = S_STEP;
                    end
                end
                S_STEP: begin
                    fetch_nxt = 1'b1;
                    count_nxt = FetchCount + 16'd1;
                    state_nxt = S_IDLE;
                end
                S_RUN: begin
                    if (bkpt_hit) begin
                        state_nxt = S_HALT;
                    end else if (!run_lvl) begin
                        state_nxt = S_IDLE;
                        tick_nxt  = '0;
                    end else if (tick == TICK_LAST) begin
                        tick_nxt  = '0;
                        fetch_nxt = 1'b1;
                        count_nxt = FetchCount + 16'd1;
                    end else begin
                        tick_nxt  = tick + TICK_W'(1);
                    end
                end
                S_HALT: begin
                    if (step_req) begin
                        state_nxt = S_STEP;
                    end else if (!run_lvl) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            tick       <= '0;
            FetchEn    <= 1'b0;
            IfuReset   <= 1'b0;
            Halted     <= 1'b0;
            FetchCount <= '0;
        end else begin
            state      <= state_nxt;
            tick       <= tick_nxt;
            FetchEn    <= fetch_nxt;
            IfuReset   <= ifu_nxt;
            Halted     <= (state_nxt == S_HALT);
            FetchCount <= count_nxt;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_fetch_step_controller.sv
// Self-checking bench for fetch_step_controller: step table, bounce, run, breakpoint,
// clear and async reset, with a scoreboard of expected FetchEn pulses (cycle and count).
module tb_fetch_step_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_sw, step_btn, clr_btn, bkpt_en;
    logic [31:0] bkpt_addr;
    logic [31:0] pc = '0;
    logic        fetch_en, ifu_reset, halted;
    logic [1:0]  state;
    logic [15:0] fetch_count;

    fetch_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(4), .PC_WIDTH(32)) dut (
        .Clk(clk), .Reset(rst_n), .RunSw(run_sw), .StepBtn(step_btn), .ClrBtn(clr_btn),
        .BkptEn(bkpt_en), .BkptAddr(bkpt_addr), .PCResult(pc),
        .FetchEn(fetch_en), .IfuReset(ifu_reset), .Halted(halted),
        .State(state), .FetchCount(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
    } exp_t;

    typedef struct {
        int unsigned hold;
        bit          pulse;
    } vec_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Fetch-unit PC model: advances by 4 per accepted fetch
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pc <= '0;
        else if (ifu_reset)  pc <= '0;
        else if (fetch_en)   pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Every FetchEn pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && fetch_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_fetch_cycle", int'(cyc), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fetch_cycle", int'(cyc), int'(e.cyc));
                chk("fetch_count_at_pulse", int'(fetch_count), int'(e.cnt));
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_fetch(input int unsigned at);
        exp_t e;
        exp_count++;
        e.cyc = at;
        e.cnt = exp_count;
        sb.push_back(e);
    endtask

    task automatic step_press(input int unsigned hold, input bit pulse);
        int unsigned n;
        n = cyc;
        if (pulse) push_fetch(n + 9);
        step_btn = 1'b1;
        tick_n(int'(hold));
        step_btn = 1'b0;
        tick_n(14);
        chk("step_count", int'(fetch_count), int'(exp_count));
        chk("step_state_idle", int'(state), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        exp_count = 0;
        tick_n(2);
    endtask

    initial begin
        vec_t        vecs [5];
        int unsigned n;

        vecs[0] = '{hold: 3,  pulse: 1'b0};
        vecs[1] = '{hold: 4,  pulse: 1'b1};
        vecs[2] = '{hold: 20, pulse: 1'b1};
        vecs[3] = '{hold: 1,  pulse: 1'b0};
        vecs[4] = '{hold: 8,  pulse: 1'b1};

        rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; clr_btn = 1'b0;
        bkpt_en = 1'b0; bkpt_addr = 32'h0;
        tick_n(3);
        chk("rst_fetch_en", int'(fetch_en), 0);
        chk("rst_ifu_reset", int'(ifu_reset), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(fetch_count), 0);
        rst_n = 1'b1;
        tick_n(2);

        // Step mode: press lengths around the debounce threshold
        for (int i = 0; i < 5; i++) step_press(vecs[i].hold, vecs[i].pulse);

        // Bouncing button never settles long enough
        for (int i = 0; i < 10; i++) begin
            step_btn = ~step_btn;
            tick_n(2);
        end
        step_btn = 1'b0;
        tick_n(12);
        chk("bounce_count", int'(fetch_count), int'(exp_count));

        // Run mode: first pulse 4 cycles after entering RUN, then every 4
        n = cyc;
        for (int j = 0; j < 9; j++) push_fetch(n + 11 + 4 * j);
        run_sw = 1'b1;
        tick_n(40);
        run_sw = 1'b0;
        tick_n(10);
        chk("run_stop_state", int'(state), 0);
        chk("run_count", int'(fetch_count), int'(exp_count));

        // Breakpoint at 0x0C halts after the third fetch
        do_reset();
        bkpt_en = 1'b1; bkpt_addr = 32'h0000_000C;
        n = cyc;
        for (int j = 0; j < 3; j++) push_fetch(n + 11 + 4 * j);
        run_sw = 1'b1;
        tick_n(21);
        chk("bkpt_halted", int'(halted), 1);
        chk("bkpt_state", int'(state), 3);
        chk("bkpt_count", int'(fetch_count), 3);
        chk("bkpt_pc", int'(pc), 12);
        tick_n(5);
        chk("bkpt_still_halted", int'(halted), 1);
        n = cyc;
        push_fetch(n + 9);
        step_btn = 1'b1;
        tick_n(3);
        run_sw = 1'b0;
        tick_n(5);
        chk("bkpt_step_state", int'(state), 2);
        tick_n(2);
        chk("bkpt_after_step_state", int'(state), 0);
        step_btn = 1'b0;
        bkpt_en = 1'b0;
        tick_n(12);
        chk("bkpt_step_count", int'(fetch_count), 4);
        chk("bkpt_unhalted", int'(halted), 0);

        // Clear lands on a tick that would have fetched; the fetch is suppressed
        do_reset();
        n = cyc;
        for (int j = 0; j < 5; j++) push_fetch(n + 11 + 4 * j);
        run_sw = 1'b1;
        tick_n(23);
        clr_btn = 1'b1;
        tick_n(3);
        run_sw = 1'b0;
        tick_n(4);
        chk("clr_pre_count", int'(fetch_count), 5);
        chk("clr_pre_ifu", int'(ifu_reset), 0);
        chk("clr_pre_state", int'(state), 1);
        tick_n(1);
        chk("clr_ifu_pulse", int'(ifu_reset), 1);
        chk("clr_no_fetch", int'(fetch_en), 0);
        chk("clr_count", int'(fetch_count), 0);
        chk("clr_state", int'(state), 0);
        exp_count = 0;
        tick_n(1);
        chk("clr_ifu_single", int'(ifu_reset), 0);
        clr_btn = 1'b0;
        tick_n(12);
        chk("clr_end_state", int'(state), 0);
        chk("clr_end_count", int'(fetch_count), 0);

        // Asynchronous reset in the middle of a FetchEn pulse
        do_reset();
        n = cyc;
        push_fetch(n + 9);
        step_btn = 1'b1;
        tick_n(9);
        chk("ar_pulse_live", int'(fetch_en), 1);
        #2;
        step_btn = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_fetch_en", int'(fetch_en), 0);
        chk("ar_state", int'(state), 0);
        chk("ar_count", int'(fetch_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        tick_n(2);
        step_press(6, 1'b1);

        chk("missing_fetches", int'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
